serial_reg_loader: RTL and testbench
====================================

Name: serial_reg_loader

Overview:
- Upstream front-end for signal_generator; replaces direct pin-driven write_strobe/address/data.
- Receives 8-bit register frames over a 3-wire serial link (ser_clk, ser_data, ser_cs_n) and buffers them in a small FIFO.
- Replays each frame as a slow write transaction: setup, then strobe, then hold.
- Strobe width is long enough to be captured by signal_generator, which runs on the scaled clock.

Parameters:
- FIFO_DEPTH, 4, frame buffer entries; power of two, ≥2.
- SETUP_CYCLES, 4, clk cycles address/data are stable before strobe rises; ≥1.
- STROBE_CYCLES, 256, clk cycles write_strobe is held high; must exceed 2× clock_scale factor; ≥1.
- HOLD_CYCLES, 4, clk cycles address/data are held after strobe falls; ≥1.

Ports:
- clk  in  1  system clock (unscaled).
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable for the transaction issuer; reception is unaffected.
- ser_clk  in  1  serial bit clock, asynchronous, slower than clk/4.
- ser_data  in  1  serial data, MSB first, sampled on ser_clk rising edge.
- ser_cs_n  in  1  frame select, active low.
- write_strobe  out  1  to signal_generator.write_strobe.
- address  out  3  to signal_generator.address.
- data  out  5  to signal_generator.data.
- busy  out  1  high while the issuer is not IDLE.
- fifo_full  out  1  FIFO holds FIFO_DEPTH frames.
- overflow  out  1  sticky: a frame was dropped.

Behaviour:
- Reset: all outputs 0; FIFO empty; shift register and bit counter 0; FSM IDLE. Takes effect on the next clk edge regardless of the current state; an in-flight strobe is aborted.
- Synchronisation:
  - ser_clk, ser_data and ser_cs_n each pass through a 2-FF synchroniser.
  - A rising edge is detected when sync_clk=1 and prev_sync_clk=0.
- Reception:
  - On a detected edge with sync_cs_n=0: shift sync_data into an 8-bit shift register LSB side (MSB first) and increment a 3-bit counter.
  - When the counter wraps from 7 to 0, the frame is complete. Frame fields: [7:5]=address, [4:0]=data.
  - sync_cs_n=1 clears the counter; a partial frame is discarded and no push occurs.
  - Back-to-back frames under continuous cs_n low are allowed.
- Push timing:
  - If the 8th ser_clk rising edge is first sampled by clk edge k, the frame is pushed at edge k+3.
  - fifo_full and the non-empty condition update after edge k+3.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push while full with no pop in the same cycle: frame dropped, overflow←1. overflow is cleared only by rst.
  - Push and pop in the same cycle: both succeed, count unchanged, including when full.
- Issuer FSM (IDLE, SETUP, STROBE, HOLD), one shared down-counter:
  - IDLE: if en=1 and FIFO non-empty, pop; load address/data from the popped entry at this edge; counter←SETUP_CYCLES-1; →SETUP.
  - SETUP: write_strobe=0. When counter=0: write_strobe←1, counter←STROBE_CYCLES-1, →STROBE.
  - STROBE: write_strobe=1. When counter=0: write_strobe←0, counter←HOLD_CYCLES-1, →HOLD.
  - HOLD: address/data unchanged. When counter=0 →IDLE.
  - address/data keep their last value in IDLE; they change only on a pop.
  - busy=1 in SETUP/STROBE/HOLD.
- Issuer timing:
  - A pop at edge p gives write_strobe high from edge p+SETUP_CYCLES to p+SETUP_CYCLES+STROBE_CYCLES.
  - Next pop at edge ≥ p+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES.
- en=0: no new pop; the current transaction completes normally.
- Throughput: one transaction per SETUP+STROBE+HOLD+1 clk cycles; the FIFO absorbs serial bursts.

Test Plan:
- Reset: hold rst high 3 cycles mid-STROBE → write_strobe, address, data, busy, overflow all 0 on the next edge; FIFO empty.
- Single frame: send 0xA6 (addr=5, data=6), SETUP=4, STROBE=256, HOLD=4 → address=5, data=6 at pop edge p; write_strobe high exactly 256 cycles starting p+4; busy low at p+264.
- Partial frame: clock 5 bits, raise cs_n, then send 0x21 → exactly one transaction, address=1, data=1.
- Overflow: with en=0, send 5 frames 0x01..0x05 → fifo_full=1 after the 4th; overflow=1 after the 5th. Then en=1 → exactly 4 transactions with data 1,2,3,4 in order; overflow stays 1.
- Simultaneous push/pop: FIFO full, a new frame completes on the same cycle the issuer pops → no overflow, count stays 4, frame issued 5th.
- en gating: drop en during STROBE → strobe completes its full 256 cycles; the next queued frame is not popped until en returns high.

Source files
------------

// File: rtl/serial_reg_loader.sv
// Serial front-end for signal_generator: receives 8-bit register frames over a
// 3-wire link, queues them, and replays each as a slow setup/strobe/hold write.
module serial_reg_loader #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 4,
  parameter int STROBE_CYCLES = 256,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ser_clk,
  input  logic       ser_data,
  input  logic       ser_cs_n,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int MAX_SU  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYC = (MAX_SU > HOLD_CYCLES) ? MAX_SU : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic [1:0]       cs_sync;
  logic             prev_sync_clk;
  logic             ser_rise;

  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt;
  logic             frame_ready;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop;
  logic [7:0]       head;

  state_t           state;
  logic [TMR_W-1:0] timer;

  // Chip select resets to the inactive level so reception starts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync      <= 2'b00;
      data_sync     <= 2'b00;
      cs_sync       <= 2'b11;
      prev_sync_clk <= 1'b0;
    end else begin
      clk_sync      <= {clk_sync[0], ser_clk};
      data_sync     <= {data_sync[0], ser_data};
      cs_sync       <= {cs_sync[0], ser_cs_n};
      prev_sync_clk <= clk_sync[1];
    end
  end

  assign ser_rise = clk_sync[1] & ~prev_sync_clk;

  // The shift register already holds the whole frame one cycle before the
  // push, and the slow bit clock guarantees it is stable for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= 8'd0;
      bit_cnt     <= 3'd0;
      frame_ready <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
      end else if (ser_rise) begin
        shift_reg <= {shift_reg[6:0], data_sync[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          frame_ready <= 1'b1;
        end
      end
    end
  end

  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = (state == IDLE) && en && (count != '0);
  assign push_ok   = frame_ready && (!fifo_full || pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (frame_ready && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      write_strobe <= 1'b0;
      address      <= 3'd0;
      data         <= 5'd0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            address <= head[7:5];
            data    <= head[4:0];
            timer   <= TMR_W'(SETUP_CYCLES - 1);
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (timer == '0) begin
            write_strobe <= 1'b1;
            timer        <= TMR_W'(STROBE_CYCLES - 1);
            state        <= STROBE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        STROBE: begin
          if (timer == '0) begin
            write_strobe <= 1'b0;
            timer        <= TMR_W'(HOLD_CYCLES - 1);
            state        <= HOLD;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        HOLD: begin
          if (timer == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_reg_loader.sv
// Bench for serial_reg_loader: serial frames in, observed write transactions
// compared against an ordered queue of accepted frames and a FIFO occupancy model.
module tb_serial_reg_loader;

  localparam int DEPTH  = 4;
  localparam int SETUP  = 4;
  localparam int STROBE = 256;
  localparam int HOLD   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_cs_n;
  logic       write_strobe;
  logic [2:0] address;
  logic [4:0] data;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  serial_reg_loader #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_cs_n(ser_cs_n), .write_strobe(write_strobe), .address(address), .data(data),
    .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [4:0] dat;
    int         pop;
    int         rise;
    int         fall;
    int         idle;
    bit         stable;
  } txn_t;

  int         cycle = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         model_occ = 0;
  bit         exp_ovf = 1'b0;
  logic [7:0] exp_q[$];
  txn_t       recs[$];
  txn_t       cur;
  logic       prev_busy = 1'b0;
  logic       prev_strobe = 1'b0;
  logic       full_pre, ovf_pre, full_post;
  logic [7:0] fr;

  always @(posedge clk) cycle++;

  // Records every write transaction the DUT issues; a busy rise is a FIFO pop.
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      cur.addr = address;
      cur.dat = data;
      cur.pop = cycle;
      cur.rise = -1;
      cur.fall = -1;
      cur.stable = 1'b1;
      model_occ--;
    end else if (busy && (address !== cur.addr || data !== cur.dat)) begin
      cur.stable = 1'b0;
    end
    if (write_strobe && !prev_strobe) cur.rise = cycle;
    if (!write_strobe && prev_strobe) cur.fall = cycle;
    if (!busy && prev_busy) begin
      cur.idle = cycle;
      recs.push_back(cur);
    end
    prev_busy = busy;
    prev_strobe = write_strobe;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Sends one frame MSB first; samples the flags just before and just after
  // the push edge (three clk edges after the final bit edge is first seen).
  task automatic applyStimulus(input logic [7:0] f, input bit en_at_push);
    ser_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      ser_data = f[i];
      repeat (4) @(negedge clk);
      ser_clk = 1'b1;
      if (i == 0) begin
        repeat (3) @(negedge clk);
        full_pre = fifo_full;
        ovf_pre = overflow;
        if (en_at_push) en = 1'b1;
        @(negedge clk);
        full_post = fifo_full;
      end else begin
        repeat (4) @(negedge clk);
      end
      ser_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ser_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    if (model_occ < DEPTH) begin
      exp_q.push_back(f);
      model_occ++;
    end else begin
      exp_ovf = 1'b1;
    end
    checkOutput("overflow_after_frame", overflow, exp_ovf);
    checkOutput("full_after_push", full_post, model_occ == DEPTH);
  endtask

  task automatic sendPartial(input int nbits);
    ser_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ser_data = 1'($urandom);
      repeat (4) @(negedge clk);
      ser_clk = 1'b1;
      repeat (4) @(negedge clk);
      ser_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ser_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic waitTxns(input int n, input int budget);
    for (int i = 0; i < budget && recs.size() < n; i++) @(negedge clk);
    #1;
    checkOutput("txn_count", recs.size(), n);
  endtask

  task automatic checkTxn();
    txn_t       r;
    logic [7:0] f;
    if (recs.size() == 0 || exp_q.size() == 0) return;
    r = recs.pop_front();
    f = exp_q.pop_front();
    checkOutput("txn_address", r.addr, f[7:5]);
    checkOutput("txn_data", r.dat, f[4:0]);
    checkOutput("setup_len", r.rise - r.pop, SETUP);
    checkOutput("strobe_len", r.fall - r.rise, STROBE);
    checkOutput("txn_len", r.idle - r.pop, SETUP + STROBE + HOLD);
    checkOutput("addr_data_stable", r.stable, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ser_clk = 1'b0; ser_data = 1'b0; ser_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_strobe", write_strobe, 0);
    checkOutput("reset_address", address, 0);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_full", fifo_full, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single frame 0xA6");
    en = 1'b1;
    applyStimulus(8'hA6, 1'b0);
    waitTxns(1, 600);
    checkTxn();
    checkOutput("addr_held_idle", address, 5);
    checkOutput("data_held_idle", data, 6);

    $display("[TB] partial frame then 0x21");
    sendPartial(5);
    applyStimulus(8'h21, 1'b0);
    waitTxns(1, 600);
    checkTxn();
    repeat (300) @(negedge clk);
    checkOutput("partial_no_extra", recs.size(), 0);

    $display("[TB] push and pop in the same cycle while full");
    en = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1'b0);
    checkOutput("full_before_sim", fifo_full, 1);
    checkOutput("idle_before_sim", busy, 0);
    applyStimulus(8'($urandom), 1'b1);
    checkOutput("sim_full_pre", full_pre, 1);
    checkOutput("sim_ovf_pre", ovf_pre, 0);
    waitTxns(5, 5 * 265 + 400);
    for (int i = 0; i < 5; i++) checkTxn();

    $display("[TB] en dropped during strobe");
    en = 1'b1;
    applyStimulus(8'($urandom), 1'b0);
    applyStimulus(8'($urandom), 1'b0);
    checkOutput("strobe_at_en_drop", write_strobe, 1);
    en = 1'b0;
    waitTxns(1, 400);
    repeat (300) @(negedge clk);
    checkOutput("held_while_en_low", recs.size(), 1);
    checkOutput("busy_while_en_low", busy, 0);
    en = 1'b1;
    waitTxns(2, 600);
    for (int i = 0; i < 2; i++) checkTxn();

    $display("[TB] random burst");
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1'b0);
    waitTxns(4, 4 * 265 + 600);
    for (int i = 0; i < 4; i++) checkTxn();

    $display("[TB] overflow with en low");
    en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      fr = 8'(i);
      applyStimulus(fr, 1'b0);
      if (i == 4) checkOutput("full_pre_4th", full_pre, 0);
      if (i == 5) checkOutput("ovf_pre_5th", ovf_pre, 0);
    end
    checkOutput("overflow_set", overflow, 1);
    en = 1'b1;
    waitTxns(4, 4 * 265 + 400);
    for (int i = 0; i < 4; i++) checkTxn();
    repeat (300) @(negedge clk);
    checkOutput("ovf_no_fifth", recs.size(), 0);
    checkOutput("ovf_sticky", overflow, 1);

    $display("[TB] reset during strobe");
    applyStimulus(8'($urandom), 1'b0);
    applyStimulus(8'($urandom), 1'b0);
    for (int i = 0; i < 300 && !write_strobe; i++) @(negedge clk);
    checkOutput("strobe_before_reset", write_strobe, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_strobe", write_strobe, 0);
    checkOutput("rst_address", address, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_full", fifo_full, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    recs.delete();
    exp_q.delete();
    model_occ = 0;
    exp_ovf = 1'b0;
    repeat (400) @(negedge clk);
    checkOutput("fifo_empty_after_reset", recs.size(), 0);
    checkOutput("idle_after_reset", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
